bitmap_scanout: RTL and testbench

Parametrised framebuffer scanout engine, successor to the combinational bitmap pixel source in the VGA top level. Holds an internal indexed-colour framebuffer and a writable RGB palette. Pixels are replicated by a power-of-two scale factor. Produces registered, sync-aligned RGB at a configurable output depth. Sits between video_sync_generator and the VGA pins; host logic loads pixels and palette through simple write ports.

---
 rtl/bitmap_scanout.sv | 186 ++++++++++++++++++
 tb/tb_bitmap_scanout.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bitmap_scanout.sv
// bitmap_scanout
//   Framebuffer scanout engine. An indexed-colour framebuffer of
//   (H_RES>>SCALE_SHIFT) x (V_RES>>SCALE_SHIFT) pixels is read in step with
//   the incoming raster position. Each pixel is replicated 2^SCALE_SHIFT times
//   in both directions, looked up in a writable 24-bit palette and quantised
//   to OUT_BITS per channel. Outputs are registered. Outputs and syncs trail
//   the raster inputs by a fixed 3 cycles.
//
//   Optional feature: define SCANOUT_DITHER_EN to apply a 2x2 ordered dither
//   before quantisation. When it is undefined, channels are truncated.
//
// Ports
//   i_clk, i_reset            pixel clock, synchronous active-high reset
//   i_hsync, i_vsync          syncs from the sync generator
//   i_hpos, i_vpos, i_visible raster position and active-video flag
//   i_fb_we/addr/data         framebuffer write port (row-major word address)
//   i_pal_we/addr/data        palette write port, data = {R,G,B} 8 bits each
//   o_hsync, o_vsync          syncs delayed to line up with the pixels
//   o_r, o_g, o_b             quantised colour, 0 while blanking
module bitmap_scanout #(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned BPP         = 4,
    parameter int unsigned OUT_BITS    = 3
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_hsync,
    input  logic                i_vsync,
    input  logic [9:0]          i_hpos,
    input  logic [9:0]          i_vpos,
    input  logic                i_visible,
    input  logic                i_fb_we,
    input  logic [14:0]         i_fb_addr,
    input  logic [BPP-1:0]      i_fb_data,
    input  logic                i_pal_we,
    input  logic [BPP-1:0]      i_pal_addr,
    input  logic [23:0]         i_pal_data,
    output logic                o_hsync,
    output logic                o_vsync,
    output logic [OUT_BITS-1:0] o_r,
    output logic [OUT_BITS-1:0] o_g,
    output logic [OUT_BITS-1:0] o_b
);

    localparam int unsigned FB_W     = H_RES >> SCALE_SHIFT;
    localparam int unsigned FB_H     = V_RES >> SCALE_SHIFT;
    localparam int unsigned FB_DEPTH = FB_W * FB_H;
    localparam int unsigned FB_AW    = $clog2(FB_DEPTH);
    localparam int unsigned PAL_N    = 1 << BPP;

    // Greyscale ramp entry: the BPP index bits repeated MSB-first over 8 bits.
    function automatic logic [7:0] grey(input int unsigned idx);
        logic [BPP-1:0] ib;
        logic [7:0]     v;
        ib = BPP'(idx);
        v  = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            v[7-j] = ib[BPP-1-(j % BPP)];
        end
        return v;
    endfunction

    logic [BPP-1:0] fb  [FB_DEPTH];
    logic [23:0]    pal [PAL_N];

    // S0
    logic [31:0]    addr_s0;
    logic           valid_s0;
    // S1
    logic [BPP-1:0] idx_s1;
    logic           valid_s1;
    // sync delay line; bit 2 drives the outputs
    logic [2:0]     hs_pipe;
    logic [2:0]     vs_pipe;

    logic [OUT_BITS-1:0] q_r, q_g, q_b;

    // ---------------- S0: address and valid ----------------
    always_ff @(posedge i_clk) begin
        addr_s0 <= ((32'(i_vpos) >> SCALE_SHIFT) * FB_W) + (32'(i_hpos) >> SCALE_SHIFT);
        if (i_reset) begin
            valid_s0 <= 1'b0;
        end else begin
            valid_s0 <= i_visible && (32'(i_hpos) < H_RES) && (32'(i_vpos) < V_RES);
        end
    end

    // ---------------- S1: framebuffer (read-first) ----------------
    always_ff @(posedge i_clk) begin
        if (!i_reset && i_fb_we && (32'(i_fb_addr) < FB_DEPTH)) begin
            fb[i_fb_addr[FB_AW-1:0]] <= i_fb_data;
        end
        // Off-screen positions can form addresses past the array; their
        // valid bit is already low, so any index will do.
        idx_s1 <= (addr_s0 < FB_DEPTH) ? fb[addr_s0[FB_AW-1:0]] : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_s1 <= 1'b0;
            hs_pipe  <= '0;
            vs_pipe  <= '0;
        end else begin
            valid_s1 <= valid_s0;
            hs_pipe  <= {hs_pipe[1:0], i_hsync};
            vs_pipe  <= {vs_pipe[1:0], i_vsync};
        end
    end

    // ---------------- palette ----------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < PAL_N; i++) begin
                pal[i] <= {3{grey(i)}};
            end
        end else if (i_pal_we) begin
            pal[i_pal_addr] <= i_pal_data;
        end
    end

    // ---------------- S2: lookup and quantise ----------------
`ifdef SCANOUT_DITHER_EN
    logic hpos0_s0, vpos0_s0, hpos0_s1, vpos0_s1;

    always_ff @(posedge i_clk) begin
        hpos0_s0 <= i_hpos[0];
        vpos0_s0 <= i_vpos[0];
        hpos0_s1 <= hpos0_s0;
        vpos0_s1 <= vpos0_s0;
    end

    function automatic logic [OUT_BITS-1:0] quant(input logic [7:0] c, input logic [8:0] t);
        logic [8:0] sum;
        logic [7:0] sat;
        sum = {1'b0, c} + t;
        sat = sum[8] ? 8'hFF : sum[7:0];
        return sat[7 -: OUT_BITS];
    endfunction

    logic [1:0] bayer;
    logic [8:0] thresh;
    logic [23:0] rgb;

    always_comb begin
        rgb = pal[idx_s1];
        // B = {{0,2},{3,1}} indexed [vpos0][hpos0]
        unique case ({vpos0_s1, hpos0_s1})
            2'b00:   bayer = 2'd0;
            2'b01:   bayer = 2'd2;
            2'b10:   bayer = 2'd3;
            default: bayer = 2'd1;
        endcase
        thresh = 9'(bayer) << (8 - OUT_BITS - 2);
        q_r = quant(rgb[23:16], thresh);
        q_g = quant(rgb[15:8],  thresh);
        q_b = quant(rgb[7:0],   thresh);
    end
`else
    logic [23:0] rgb;

    always_comb begin
        rgb = pal[idx_s1];
        q_r = rgb[23 -: OUT_BITS];
        q_g = rgb[15 -: OUT_BITS];
        q_b = rgb[7  -: OUT_BITS];
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset || !valid_s1) begin
            o_r <= '0;
            o_g <= '0;
            o_b <= '0;
        end else begin
            o_r <= q_r;
            o_g <= q_g;
            o_b <= q_b;
        end
    end

    assign o_hsync = hs_pipe[2];
    assign o_vsync = vs_pipe[2];

endmodule

// File: tb/tb_bitmap_scanout.sv
// Directed bench for bitmap_scanout: latency/sync alignment, pixel
// replication, blanking, write-port bounds and ordering, reset recovery,
// and the dither pattern on a mid-grey entry.
module tb_bitmap_scanout;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync, vsync;
    logic [9:0] hpos, vpos;
    logic       visible;
    logic       fb_we;
    logic [14:0] fb_addr;
    logic [3:0] fb_data;
    logic       pal_we;
    logic [3:0] pal_addr;
    logic [23:0] pal_data;
    logic       o_hsync, o_vsync;
    logic [2:0] o_r, o_g, o_b;

    int total = 0;
    int bad   = 0;

    bitmap_scanout #(
        .H_RES(640), .V_RES(480), .SCALE_SHIFT(2), .BPP(4), .OUT_BITS(3)
    ) dut (
        .i_clk(clk), .i_reset(reset),
        .i_hsync(hsync), .i_vsync(vsync),
        .i_hpos(hpos), .i_vpos(vpos), .i_visible(visible),
        .i_fb_we(fb_we), .i_fb_addr(fb_addr), .i_fb_data(fb_data),
        .i_pal_we(pal_we), .i_pal_addr(pal_addr), .i_pal_data(pal_data),
        .o_hsync(o_hsync), .o_vsync(o_vsync),
        .o_r(o_r), .o_g(o_g), .o_b(o_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare {hsync,vsync,r,g,b} against the expected tuple.
    task automatic chk(input string tag, input logic hs, input logic vs,
                       input logic [2:0] r, input logic [2:0] g, input logic [2:0] b);
        logic [10:0] obs, exp;
        obs = {o_hsync, o_vsync, o_r, o_g, o_b};
        exp = {hs, vs, r, g, b};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed hs=%b vs=%b rgb=%o%o%o expected hs=%b vs=%b rgb=%o%o%o",
                   tag, obs[10], obs[9], obs[8:6], obs[5:3], obs[2:0],
                   hs, vs, r, g, b);
        end
    endtask

    task automatic fb_write(input int a, input logic [3:0] d);
        fb_we = 1'b1; fb_addr = 15'(a); fb_data = d;
        tick();
        fb_we = 1'b0;
    endtask

    task automatic pal_write(input logic [3:0] a, input logic [23:0] d);
        pal_we = 1'b1; pal_addr = a; pal_data = d;
        tick();
        pal_we = 1'b0;
    endtask

    // Hold a raster position for the full pipeline depth, then check colour.
    task automatic px(input string tag, input int h, input int v, input logic vis,
                      input logic [2:0] r, input logic [2:0] g, input logic [2:0] b);
        hpos = 10'(h); vpos = 10'(v); visible = vis; hsync = 1'b0; vsync = 1'b0;
        repeat (3) tick();
        chk(tag, 1'b0, 1'b0, r, g, b);
    endtask

    initial begin
        reset = 1'b1; hsync = 1'b1; vsync = 1'b1;
        hpos = '0; vpos = '0; visible = 1'b0;
        fb_we = 1'b0; fb_addr = '0; fb_data = '0;
        pal_we = 1'b0; pal_addr = '0; pal_data = '0;

        // reset state: outputs and delayed syncs held low
        repeat (3) tick();
        chk("reset_state", 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
        reset = 1'b0; hsync = 1'b0; vsync = 1'b0;

        fb_write(0, 4'hF);
        fb_write(2, 4'hA);
        fb_write(161, 4'h3);
        fb_write(160, 4'hF);
        fb_write(19199, 4'hF);

        // exact 3-cycle latency, syncs aligned with pixels
        hpos = 10'd0; vpos = 10'd0; visible = 1'b1; hsync = 1'b1; vsync = 1'b0;
        tick();
        hpos = 10'd700; visible = 1'b0; hsync = 1'b0; vsync = 1'b1;
        tick();
        chk("lat_cycle2", 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
        hsync = 1'b0; vsync = 1'b0;
        tick();
        chk("lat_cycle3", 1'b1, 1'b0, 3'd7, 3'd7, 3'd7);
        tick();
        chk("lat_cycle4", 1'b0, 1'b1, 3'd0, 3'd0, 3'd0);

        // replication: fb[1] covers hpos 4..7, vpos 0..3
        fb_write(1, 4'h5);
        pal_write(4'h5, 24'hFF0000);
        px("rep_h4_v0", 4, 0, 1'b1, 3'd7, 3'd0, 3'd0);
        px("rep_h7_v0", 7, 0, 1'b1, 3'd7, 3'd0, 3'd0);
        px("rep_h4_v3", 4, 3, 1'b1, 3'd7, 3'd0, 3'd0);
        px("rep_h7_v3", 7, 3, 1'b1, 3'd7, 3'd0, 3'd0);
        px("rep_h3",    3, 0, 1'b1, 3'd7, 3'd7, 3'd7);
        px("rep_h8",    8, 0, 1'b1, 3'd5, 3'd5, 3'd5);
        px("rep_v4",    4, 4, 1'b1, 3'd1, 3'd1, 3'd1);
        px("last_px",   639, 479, 1'b1, 3'd7, 3'd7, 3'd7);

        // blanking
        px("blank_vis0",  0, 0,   1'b0, 3'd0, 3'd0, 3'd0);
        px("blank_h700",  700, 0, 1'b1, 3'd0, 3'd0, 3'd0);
        px("blank_h640",  640, 0, 1'b1, 3'd0, 3'd0, 3'd0);
        px("blank_v480",  0, 480, 1'b1, 3'd0, 3'd0, 3'd0);

        // out-of-range write ignored
        fb_write(19200, 4'h0);
        fb_write(32767, 4'h0);
        px("oob_write", 0, 0, 1'b1, 3'd7, 3'd7, 3'd7);

        // same-cycle write/read of fb[0]: old data first, new next
        hpos = 10'd0; vpos = 10'd0; visible = 1'b1;
        tick();
        fb_we = 1'b1; fb_addr = 15'd0; fb_data = 4'h5;
        tick();
        fb_we = 1'b0;
        tick();
        chk("fb_rw_old", 1'b0, 1'b0, 3'd7, 3'd7, 3'd7);
        tick();
        chk("fb_rw_new", 1'b0, 1'b0, 3'd7, 3'd0, 3'd0);

        // same-cycle palette write/lookup of entry A
        hpos = 10'd8; vpos = 10'd0; visible = 1'b1;
        repeat (2) tick();
        pal_we = 1'b1; pal_addr = 4'hA; pal_data = 24'h00FF00;
        tick();
        pal_we = 1'b0;
        chk("pal_rw_old", 1'b0, 1'b0, 3'd5, 3'd5, 3'd5);
        tick();
        chk("pal_rw_new", 1'b0, 1'b0, 3'd0, 3'd7, 3'd0);

        // reset mid-line; writes during reset are dropped
        hpos = 10'd4; vpos = 10'd0; visible = 1'b1; hsync = 1'b1;
        repeat (3) tick();
        chk("pre_reset", 1'b1, 1'b0, 3'd7, 3'd0, 3'd0);
        reset = 1'b1;
        fb_we = 1'b1; fb_addr = 15'd1; fb_data = 4'h0;
        pal_we = 1'b1; pal_addr = 4'h5; pal_data = 24'h000000;
        tick();
        chk("reset_mid", 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
        reset = 1'b0; fb_we = 1'b0; pal_we = 1'b0; hsync = 1'b0;
        tick();
        chk("rel_cycle1", 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
        tick();
        chk("rel_cycle2", 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
        tick();
        chk("rel_cycle3", 1'b0, 1'b0, 3'd2, 3'd2, 3'd2);
        px("grey_A", 8, 0, 1'b1, 3'd5, 3'd5, 3'd5);

        // dither on entry 0x303030
        pal_write(4'h3, 24'h303030);
        fb_write(3, 4'h3);
`ifdef SCANOUT_DITHER_EN
        px("dith_x0y0", 12, 0, 1'b1, 3'd1, 3'd1, 3'd1);
        px("dith_x1y0", 13, 0, 1'b1, 3'd2, 3'd2, 3'd2);
        px("dith_x0y1", 12, 1, 1'b1, 3'd2, 3'd2, 3'd2);
        px("dith_x1y1", 13, 1, 1'b1, 3'd1, 3'd1, 3'd1);
`else
        px("dith_x0y0", 12, 0, 1'b1, 3'd1, 3'd1, 3'd1);
        px("dith_x1y0", 13, 0, 1'b1, 3'd1, 3'd1, 3'd1);
        px("dith_x0y1", 12, 1, 1'b1, 3'd1, 3'd1, 3'd1);
        px("dith_x1y1", 13, 1, 1'b1, 3'd1, 3'd1, 3'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
